sync_fifo_ctrl: RTL and testbench
=================================

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default `FIFO_DEPTH, number of memory entries; SHALL be a power of two, >= 4.
REQ-002 Parameter ADDR_WIDTH, default $clog2(MEM_DEPTH), memory address width.
REQ-003 Parameter AFULL_THRESH, default MEM_DEPTH-2, count at or above which almost_full asserts.
REQ-004 Parameter AEMPTY_THRESH, default 2, count at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 wr_req  input  1  producer push request.
REQ-008 rd_req  input  1  consumer pop request.
REQ-009 wr_en  output  1  memory write strobe (combinational, = accepted push).
REQ-010 wr_addr  output  ADDR_WIDTH  memory write address (registered write pointer, low bits).
REQ-011 rd_addr  output  ADDR_WIDTH  memory read address (registered read pointer, low bits).
REQ-012 full  output  1  no free entry.
REQ-013 empty  output  1  no stored entry.
REQ-014 almost_full  output  1  data_count >= AFULL_THRESH.
REQ-015 almost_empty  output  1  data_count <= AEMPTY_THRESH.
REQ-016 data_count  output  ADDR_WIDTH+1  stored entries, 0..MEM_DEPTH.
REQ-017 overflow  output  1  registered one-cycle pulse: push rejected in previous cycle.
REQ-018 underflow  output  1  registered one-cycle pulse: pop rejected in previous cycle.

Function
REQ-019 Write and read pointers SHALL be ADDR_WIDTH+1 bits; MSB is a wrap bit, low ADDR_WIDTH bits drive wr_addr/rd_addr.
REQ-020 empty SHALL be 1 when pointers are equal; full SHALL be 1 when low bits are equal and wrap bits differ; both are decoded from registered pointers.
REQ-021 Push accepted (wr_acc) = wr_req & (!full | rd_acc); pop accepted (rd_acc) = rd_req & !empty.
REQ-022 wr_en SHALL equal wr_acc in the same cycle; write pointer increments by 1 on the following edge, wrapping modulo 2*MEM_DEPTH.
REQ-023 Read is first-word-fall-through: while !empty the memory output at rd_addr is the head entry; rd_acc advances the read pointer on the following edge.
REQ-024 data_count SHALL be the registered difference write pointer minus read pointer, modulo 2^(ADDR_WIDTH+1).
REQ-025 Full with wr_req & rd_req: both accepted, data_count unchanged, full stays 1.
REQ-026 Empty with wr_req & rd_req: push only accepted, pop rejected, underflow pulses next cycle, empty deasserts next cycle.
REQ-027 Neither full nor empty, both requests: both accepted, data_count unchanged.
REQ-028 wr_req & full & !rd_req: no pointer change, wr_en = 0, overflow = 1 for exactly one cycle after.
REQ-029 rd_req & empty: no pointer change, underflow = 1 for exactly one cycle after.
REQ-030 Flag/count latency: full, empty, almost_*, data_count reflect an accepted push/pop one cycle after the accepting edge.

Reset
REQ-031 reset_n low SHALL immediately clear both pointers, overflow, underflow; outputs: wr_addr = 0, rd_addr = 0, data_count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, wr_en = wr_req & 1 is masked to 0 while reset_n is low.
REQ-032 Reset asserted mid-operation discards all stored entries; the first push after release writes address 0.
REQ-033 Release of reset_n SHALL be sampled synchronously; no push or pop is accepted on the edge at which reset_n is still low.

Verification (MEM_DEPTH = 8, AFULL_THRESH = 6, AEMPTY_THRESH = 2)
REQ-034 Reset, then 8 pushes -> wr_addr 0..7 with wr_en = 1, then full = 1, data_count = 8, almost_full = 1 from count 6, wr_addr = 0.
REQ-035 Full, push without pop -> wr_en = 0, pointers unchanged, overflow = 1 for one cycle, data_count = 8.
REQ-036 Full, push + pop for 10 cycles -> data_count stays 8, full stays 1, rd_addr and wr_addr wrap 7 -> 0.
REQ-037 Empty, pop only -> underflow = 1 for one cycle; empty, push + pop -> data_count = 1, empty = 0, underflow = 1.
REQ-038 Drain 8 entries after fill -> rd_addr 0..7, empty = 1 after 8th pop, almost_empty = 1 at count <= 2.
REQ-039 Push 5, assert reset_n low mid-cycle -> outputs reach reset values without a clock edge; next push uses wr_addr = 0.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointer, flag and count controller for a single-clock first-word-fall-through FIFO.
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 8
`endif
module sync_fifo_ctrl #(
    parameter int MEM_DEPTH     = `FIFO_DEPTH,
    parameter int ADDR_WIDTH    = $clog2(MEM_DEPTH),
    parameter int AFULL_THRESH  = MEM_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_req,
    input  logic                  rd_req,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  overflow,
    output logic                  underflow
);
    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
    logic                wr_acc, rd_acc;
    // MSB of each pointer is a wrap bit that separates full from empty
    assign empty        = wr_ptr == rd_ptr;
    assign full         = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign rd_acc       = rd_req && !empty;
    assign wr_acc       = wr_req && (!full || rd_acc) && reset_n;
    assign wr_en        = wr_acc;
    assign wr_addr      = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_addr      = rd_ptr[ADDR_WIDTH-1:0];
    assign data_count   = wr_ptr - rd_ptr;
    assign almost_full  = data_count >= (ADDR_WIDTH+1)'(AFULL_THRESH);
    assign almost_empty = data_count <= (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + (ADDR_WIDTH+1)'(wr_acc);
            rd_ptr    <= rd_ptr + (ADDR_WIDTH+1)'(rd_acc);
            overflow  <= wr_req && !wr_acc;
            underflow <= rd_req && !rd_acc;
        end
    end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: randomized and directed stimulus against an occupancy-count model, scoreboard-checked.
module tb_sync_fifo_ctrl;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;
    logic       clk = 0, reset_n = 0, wr_req = 0, rd_req = 0;
    logic       wr_en, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0] wr_addr, rd_addr;
    logic [3:0] data_count;
    typedef struct {
        int wr_en, wr_addr, rd_addr, full, empty, af, ae, cnt, ovf, udf;
    } exp_t;
    exp_t exp_q[$];
    int   n_chk = 0, n_fail = 0;
    int   pushes = 0, pops = 0, prev_ovf = 0, prev_udf = 0;

    sync_fifo_ctrl #(.MEM_DEPTH(DEPTH), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
        .clk(clk), .reset_n(reset_n), .wr_req(wr_req), .rd_req(rd_req),
        .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .data_count(data_count), .overflow(overflow), .underflow(underflow)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one cycle of requests and queue the outputs the model predicts for it
    task automatic cyc(input int w, input int r);
        exp_t e;
        int   cnt, ra, wa;
        @(negedge clk);
        wr_req = w[0];
        rd_req = r[0];
        cnt = pushes - pops;
        ra  = (r != 0 && cnt > 0) ? 1 : 0;
        wa  = (w != 0 && (cnt < DEPTH || ra != 0)) ? 1 : 0;
        e.wr_en   = wa;
        e.wr_addr = pushes % DEPTH;
        e.rd_addr = pops % DEPTH;
        e.full    = (cnt == DEPTH) ? 1 : 0;
        e.empty   = (cnt == 0) ? 1 : 0;
        e.af      = (cnt >= AF) ? 1 : 0;
        e.ae      = (cnt <= AE) ? 1 : 0;
        e.cnt     = cnt;
        e.ovf     = prev_ovf;
        e.udf     = prev_udf;
        exp_q.push_back(e);
        pushes   += wa;
        pops     += ra;
        prev_ovf  = (w != 0 && wa == 0) ? 1 : 0;
        prev_udf  = (r != 0 && ra == 0) ? 1 : 0;
    endtask

    task automatic reset_checks();
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_count", int'(data_count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_aempty", int'(almost_empty), 1);
        chk("rst_afull", int'(almost_full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_underflow", int'(underflow), 0);
        chk("rst_wr_en_masked", int'(wr_en), 0);
    endtask

    // Assert reset between clock edges, check outputs before any edge, hold through edges with requests high
    task automatic mid_reset();
        @(negedge clk);
        wr_req = 1;
        rd_req = 1;
        #5 reset_n = 0;
        #1 reset_checks();
        @(negedge clk);
        @(negedge clk);
        reset_checks();
        reset_n  = 1;
        wr_req   = 0;
        rd_req   = 0;
        pushes   = 0;
        pops     = 0;
        prev_ovf = 0;
        prev_udf = 0;
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        #3;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_en", int'(wr_en), e.wr_en);
            chk("wr_addr", int'(wr_addr), e.wr_addr);
            chk("rd_addr", int'(rd_addr), e.rd_addr);
            chk("full", int'(full), e.full);
            chk("empty", int'(empty), e.empty);
            chk("almost_full", int'(almost_full), e.af);
            chk("almost_empty", int'(almost_empty), e.ae);
            chk("data_count", int'(data_count), e.cnt);
            chk("overflow", int'(overflow), e.ovf);
            chk("underflow", int'(underflow), e.udf);
        end
    end

    initial begin
        int bias_w, bias_r;
        wr_req = 1;
        #1 reset_checks();
        @(negedge clk);
        reset_n = 1;
        wr_req  = 0;
        repeat (DEPTH) cyc(1, 0);
        cyc(1, 0);
        cyc(0, 0);
        cyc(0, 0);
        repeat (10) cyc(1, 1);
        repeat (DEPTH) cyc(0, 1);
        cyc(0, 1);
        cyc(0, 0);
        cyc(1, 1);
        cyc(0, 0);
        cyc(0, 1);
        cyc(0, 1);
        repeat (5) cyc(1, 0);
        mid_reset();
        repeat (3) cyc(1, 0);
        for (int p = 0; p < 8; p++) begin
            bias_w = (p % 2 == 0) ? 75 : 25;
            bias_r = 100 - bias_w;
            repeat (50) cyc(($urandom_range(0, 99) < bias_w) ? 1 : 0, ($urandom_range(0, 99) < bias_r) ? 1 : 0);
        end
        repeat (2) @(negedge clk);
        #5 chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
